pin_entry_controller: RTL and testbench

Sequential front end that drives the combinational account authenticator. It latches the card's account number and assembles a four-digit decimal PIN from keypad digits. It presents both to the authenticator, samples the found/authenticated result, and enforces a per-account failed-attempt lockout. It sits between the card/keypad interface and the transaction FSM, which it releases through `session_active`.

---
 rtl/pin_entry_controller.sv | 183 ++++++++++++++++++
 tb/tb_pin_entry_controller.sv | 344 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pin_entry_controller.sv
// Card/keypad front end for the account authenticator: latches the account number,
// builds a four-digit decimal PIN, samples the result and enforces per-account lockout.
module pin_entry_controller #(
    parameter int MAX_ATTEMPTS   = 3,
    parameter int TIMEOUT_CYCLES = 1000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        card_valid,
    input  logic [3:0]  card_acc_num,
    input  logic        digit_valid,
    input  logic [3:0]  digit,
    input  logic        clear,
    input  logic        cancel,
    input  logic        session_end,
    input  logic        acc_found_stat,
    input  logic        acc_auth_stat,
    input  logic [3:0]  acc_index_in,
    output logic [3:0]  acc_num,
    output logic [15:0] pin,
    output logic [3:0]  acc_index_out,
    output logic        session_active,
    output logic        auth_ok,
    output logic        pin_fail,
    output logic        card_reject,
    output logic        locked_reject,
    output logic        lockout,
    output logic        digit_err,
    output logic        timeout,
    output logic [1:0]  attempts
);

    localparam int TIMER_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(TIMEOUT_CYCLES - 1);
    localparam logic [1:0] ATTEMPT_LIMIT = 2'(MAX_ATTEMPTS);

    typedef enum logic [2:0] {IDLE, ENTER, CHECK, GRANTED, LOCK} state_t;

    state_t             state, state_next;
    logic [15:0]        lock_mask, lock_mask_next;
    logic [2:0]         count, count_next;
    logic [TIMER_W-1:0] timer, timer_next;
    logic [3:0]         acc_num_next, acc_index_next;
    logic [15:0]        pin_next;
    logic [1:0]         attempts_next;
    logic               auth_ok_next, pin_fail_next, card_reject_next, locked_reject_next;
    logic               lockout_next, digit_err_next, timeout_next;

    assign session_active = (state == GRANTED);

    always_comb begin
        state_next         = state;
        lock_mask_next     = lock_mask;
        count_next         = count;
        timer_next         = timer;
        acc_num_next       = acc_num;
        acc_index_next     = acc_index_out;
        pin_next           = pin;
        attempts_next      = attempts;
        auth_ok_next       = 1'b0;
        pin_fail_next      = 1'b0;
        card_reject_next   = 1'b0;
        locked_reject_next = 1'b0;
        lockout_next       = 1'b0;
        digit_err_next     = 1'b0;
        timeout_next       = 1'b0;

        case (state)
            IDLE: begin
                if (card_valid) begin
                    acc_num_next  = card_acc_num;
                    pin_next      = 16'd0;
                    count_next    = 3'd0;
                    timer_next    = '0;
                    attempts_next = 2'd0;
                    state_next    = ENTER;
                end
            end
            ENTER: begin
                if (cancel) begin
                    pin_next   = 16'd0;
                    count_next = 3'd0;
                    state_next = IDLE;
                end else if (clear) begin
                    // clear wins over a digit strobed in the same cycle
                    pin_next   = 16'd0;
                    count_next = 3'd0;
                    timer_next = '0;
                end else if (digit_valid) begin
                    timer_next = '0;
                    if (digit <= 4'd9) begin
                        pin_next   = (pin * 16'd10) + {12'd0, digit};
                        count_next = count + 3'd1;
                        if (count == 3'd3) state_next = CHECK;
                    end else begin
                        digit_err_next = 1'b1;
                    end
                end else if (timer == TIMER_LAST) begin
                    timeout_next = 1'b1;
                    pin_next     = 16'd0;
                    count_next   = 3'd0;
                    state_next   = IDLE;
                end else begin
                    timer_next = timer + 1'b1;
                end
            end
            CHECK: begin
                if (!acc_found_stat) begin
                    card_reject_next = 1'b1;
                    state_next       = IDLE;
                end else if (lock_mask[acc_index_in]) begin
                    locked_reject_next = 1'b1;
                    state_next         = IDLE;
                end else if (acc_auth_stat) begin
                    auth_ok_next   = 1'b1;
                    acc_index_next = acc_index_in;
                    state_next     = GRANTED;
                end else begin
                    attempts_next = attempts + 2'd1;
                    if (attempts + 2'd1 == ATTEMPT_LIMIT) begin
                        state_next = LOCK;
                    end else begin
                        pin_fail_next = 1'b1;
                        pin_next      = 16'd0;
                        count_next    = 3'd0;
                        timer_next    = '0;
                        state_next    = ENTER;
                    end
                end
            end
            LOCK: begin
                // acc_num/pin are unchanged, so acc_index_in still names the failing account
                lock_mask_next[acc_index_in] = 1'b1;
                lockout_next = 1'b1;
                state_next   = IDLE;
            end
            GRANTED: begin
                if (session_end || cancel) begin
                    pin_next   = 16'd0;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            lock_mask     <= 16'd0;
            count         <= 3'd0;
            timer         <= '0;
            acc_num       <= 4'd0;
            acc_index_out <= 4'd0;
            pin           <= 16'd0;
            attempts      <= 2'd0;
            auth_ok       <= 1'b0;
            pin_fail      <= 1'b0;
            card_reject   <= 1'b0;
            locked_reject <= 1'b0;
            lockout       <= 1'b0;
            digit_err     <= 1'b0;
            timeout       <= 1'b0;
        end else begin
            state         <= state_next;
            lock_mask     <= lock_mask_next;
            count         <= count_next;
            timer         <= timer_next;
            acc_num       <= acc_num_next;
            acc_index_out <= acc_index_next;
            pin           <= pin_next;
            attempts      <= attempts_next;
            auth_ok       <= auth_ok_next;
            pin_fail      <= pin_fail_next;
            card_reject   <= card_reject_next;
            locked_reject <= locked_reject_next;
            lockout       <= lockout_next;
            digit_err     <= digit_err_next;
            timeout       <= timeout_next;
        end
    end

endmodule

// File: tb/tb_pin_entry_controller.sv
// Directed bench for pin_entry_controller with a behavioural authenticator:
// accounts 1..5 exist at index acc-1 with PIN acc*1111+123 (1234, 2345, ...).
module tb_pin_entry_controller;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        card_valid = 1'b0;
    logic [3:0]  card_acc_num = 4'd0;
    logic        digit_valid = 1'b0;
    logic [3:0]  digit = 4'd0;
    logic        clear = 1'b0;
    logic        cancel = 1'b0;
    logic        session_end = 1'b0;
    logic        acc_found_stat, acc_auth_stat;
    logic [3:0]  acc_index_in;
    logic [3:0]  acc_num;
    logic [15:0] pin;
    logic [3:0]  acc_index_out;
    logic        session_active, auth_ok, pin_fail, card_reject, locked_reject;
    logic        lockout, digit_err, timeout;
    logic [1:0]  attempts;

    int vectors = 0;
    int miscompares = 0;
    int derr_seen = 0;
    int tmo_seen = 0;

    pin_entry_controller #(.MAX_ATTEMPTS(3), .TIMEOUT_CYCLES(1000)) dut (
        .clk(clk), .rst(rst), .card_valid(card_valid), .card_acc_num(card_acc_num),
        .digit_valid(digit_valid), .digit(digit), .clear(clear), .cancel(cancel),
        .session_end(session_end), .acc_found_stat(acc_found_stat),
        .acc_auth_stat(acc_auth_stat), .acc_index_in(acc_index_in),
        .acc_num(acc_num), .pin(pin), .acc_index_out(acc_index_out),
        .session_active(session_active), .auth_ok(auth_ok), .pin_fail(pin_fail),
        .card_reject(card_reject), .locked_reject(locked_reject), .lockout(lockout),
        .digit_err(digit_err), .timeout(timeout), .attempts(attempts)
    );

    always #5 clk = ~clk;

    always_comb begin
        acc_found_stat = (acc_num >= 4'd1) && (acc_num <= 4'd5);
        acc_index_in   = acc_num - 4'd1;
        acc_auth_stat  = acc_found_stat && (pin == (16'(acc_num) * 16'd1111 + 16'd123));
    end

    always @(negedge clk) begin
        if (digit_err) derr_seen++;
        if (timeout) tmo_seen++;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic insert_card(input logic [3:0] n);
        card_valid = 1'b1; card_acc_num = n;
        step();
        card_valid = 1'b0;
    endtask

    task automatic press(input logic [3:0] d);
        digit_valid = 1'b1; digit = d;
        step();
        digit_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step(); step();
        rst = 1'b0;
        vectors++;
        if (acc_num !== 4'd0 || pin !== 16'd0 || acc_index_out !== 4'd0 || attempts !== 2'd0) begin
            miscompares++;
            $display("FAIL reset_regs: acc_num=%0d pin=%0d idx=%0d att=%0d, required all 0",
                     acc_num, pin, acc_index_out, attempts);
        end
        vectors++;
        if ({session_active, auth_ok, pin_fail, card_reject, locked_reject, lockout, digit_err, timeout} !== 8'd0) begin
            miscompares++;
            $display("FAIL reset_flags: got %b, required 00000000",
                     {session_active, auth_ok, pin_fail, card_reject, locked_reject, lockout, digit_err, timeout});
        end
    endtask

    task automatic test_grant();
        insert_card(4'd1);
        vectors++;
        if (acc_num !== 4'd1 || pin !== 16'd0) begin
            miscompares++;
            $display("FAIL card_latch: acc_num=%0d pin=%0d, required 1/0", acc_num, pin);
        end
        press(4'd1); press(4'd2); press(4'd3); press(4'd4);
        vectors++;
        if (pin !== 16'd1234 || auth_ok !== 1'b0) begin
            miscompares++;
            $display("FAIL pin_build: pin=%0d auth_ok=%b, required 1234/0", pin, auth_ok);
        end
        step();
        vectors++;
        if (auth_ok !== 1'b1 || session_active !== 1'b1 || acc_index_out !== 4'd0) begin
            miscompares++;
            $display("FAIL grant1: auth_ok=%b active=%b idx=%0d, required 1/1/0",
                     auth_ok, session_active, acc_index_out);
        end
        insert_card(4'd5);
        vectors++;
        if (auth_ok !== 1'b0 || session_active !== 1'b1 || acc_num !== 4'd1) begin
            miscompares++;
            $display("FAIL grant_hold: auth_ok=%b active=%b acc=%0d, required 0/1/1",
                     auth_ok, session_active, acc_num);
        end
        session_end = 1'b1;
        step();
        session_end = 1'b0;
        vectors++;
        if (session_active !== 1'b0 || pin !== 16'd0) begin
            miscompares++;
            $display("FAIL session_end: active=%b pin=%0d, required 0/0", session_active, pin);
        end
    endtask

    task automatic test_lockout();
        insert_card(4'd3);
        for (int a = 1; a <= 3; a++) begin
            press(4'd1); press(4'd1); press(4'd1); press(4'd1);
            step();
            if (a < 3) begin
                vectors++;
                if (pin_fail !== 1'b1 || attempts !== 2'(a) || pin !== 16'd0 || auth_ok !== 1'b0) begin
                    miscompares++;
                    $display("FAIL pin_fail_%0d: pin_fail=%b att=%0d pin=%0d auth=%b, required 1/%0d/0/0",
                             a, pin_fail, attempts, pin, auth_ok, a);
                end
            end else begin
                vectors++;
                if (pin_fail !== 1'b0 || attempts !== 2'd3 || lockout !== 1'b0) begin
                    miscompares++;
                    $display("FAIL third_fail: pin_fail=%b att=%0d lockout=%b, required 0/3/0",
                             pin_fail, attempts, lockout);
                end
            end
        end
        step();
        vectors++;
        if (lockout !== 1'b1) begin
            miscompares++;
            $display("FAIL lockout_pulse: got %b, required 1", lockout);
        end
        step();
        vectors++;
        if (lockout !== 1'b0) begin
            miscompares++;
            $display("FAIL lockout_width: got %b, required 0", lockout);
        end
        insert_card(4'd3);
        press(4'd3); press(4'd4); press(4'd5); press(4'd6);
        step();
        vectors++;
        if (locked_reject !== 1'b1 || auth_ok !== 1'b0 || session_active !== 1'b0) begin
            miscompares++;
            $display("FAIL locked_reject: lr=%b auth=%b active=%b, required 1/0/0",
                     locked_reject, auth_ok, session_active);
        end
        step();
        vectors++;
        if (locked_reject !== 1'b0 || auth_ok !== 1'b0 || session_active !== 1'b0) begin
            miscompares++;
            $display("FAIL locked_after: lr=%b auth=%b active=%b, required 0/0/0",
                     locked_reject, auth_ok, session_active);
        end
    endtask

    task automatic test_card_reject();
        insert_card(4'd12);
        press(4'd5); press(4'd5); press(4'd5); press(4'd5);
        step();
        vectors++;
        if (card_reject !== 1'b1 || auth_ok !== 1'b0) begin
            miscompares++;
            $display("FAIL card_reject: got %b auth=%b, required 1/0", card_reject, auth_ok);
        end
        press(4'd1);
        vectors++;
        if (card_reject !== 1'b0 || pin !== 16'd5555) begin
            miscompares++;
            $display("FAIL reject_idle: cr=%b pin=%0d, required 0/5555", card_reject, pin);
        end
    endtask

    task automatic test_digit_err();
        int d0;
        d0 = derr_seen;
        insert_card(4'd2);
        press(4'd2);
        press(4'hA);
        vectors++;
        if (digit_err !== 1'b1 || pin !== 16'd2) begin
            miscompares++;
            $display("FAIL digit_err: err=%b pin=%0d, required 1/2", digit_err, pin);
        end
        press(4'd3);
        vectors++;
        if (digit_err !== 1'b0 || pin !== 16'd23) begin
            miscompares++;
            $display("FAIL after_err: err=%b pin=%0d, required 0/23", digit_err, pin);
        end
        clear = 1'b1;
        press(4'd9);
        clear = 1'b0;
        vectors++;
        if (pin !== 16'd0) begin
            miscompares++;
            $display("FAIL clear_wins: pin=%0d, required 0", pin);
        end
        press(4'd2); press(4'd3); press(4'd4); press(4'd5);
        vectors++;
        if (pin !== 16'd2345) begin
            miscompares++;
            $display("FAIL pin_2345: pin=%0d, required 2345", pin);
        end
        step();
        vectors++;
        if (auth_ok !== 1'b1 || acc_index_out !== 4'd1 || derr_seen - d0 !== 1) begin
            miscompares++;
            $display("FAIL grant2: auth=%b idx=%0d errs=%0d, required 1/1/1",
                     auth_ok, acc_index_out, derr_seen - d0);
        end
        cancel = 1'b1;
        step();
        cancel = 1'b0;
        vectors++;
        if (session_active !== 1'b0 || pin !== 16'd0) begin
            miscompares++;
            $display("FAIL cancel_granted: active=%b pin=%0d, required 0/0", session_active, pin);
        end
    endtask

    task automatic test_timeout();
        int n;
        int t0;
        bit seen;
        insert_card(4'd5);
        press(4'd1); press(4'd2);
        t0 = tmo_seen;
        n = 0;
        seen = 1'b0;
        while (!seen && n < 1100) begin
            step();
            n++;
            if (timeout) seen = 1'b1;
        end
        vectors++;
        if (!seen || n !== 1000) begin
            miscompares++;
            $display("FAIL timeout_cycles: seen=%b after %0d idle cycles, required 1 after 1000", seen, n);
        end
        vectors++;
        if (pin !== 16'd0) begin
            miscompares++;
            $display("FAIL timeout_pin: pin=%0d, required 0", pin);
        end
        for (int i = 0; i < 20; i++) step();
        press(4'd7);
        vectors++;
        if (tmo_seen - t0 !== 1 || pin !== 16'd0) begin
            miscompares++;
            $display("FAIL timeout_once: pulses=%0d pin=%0d, required 1/0", tmo_seen - t0, pin);
        end
    endtask

    task automatic test_cancel_restart();
        insert_card(4'd4);
        press(4'd1); press(4'd1); press(4'd1); press(4'd1);
        step();
        vectors++;
        if (pin_fail !== 1'b1 || attempts !== 2'd1) begin
            miscompares++;
            $display("FAIL c4_fail: pin_fail=%b att=%0d, required 1/1", pin_fail, attempts);
        end
        press(4'd7);
        cancel = 1'b1;
        step();
        cancel = 1'b0;
        vectors++;
        if (pin !== 16'd0 || attempts !== 2'd1) begin
            miscompares++;
            $display("FAIL cancel_enter: pin=%0d att=%0d, required 0/1", pin, attempts);
        end
        insert_card(4'd4);
        vectors++;
        if (attempts !== 2'd0) begin
            miscompares++;
            $display("FAIL attempts_restart: got %0d, required 0", attempts);
        end
        press(4'd4); press(4'd5); press(4'd6); press(4'd7);
        step();
        vectors++;
        if (auth_ok !== 1'b1 || acc_index_out !== 4'd3 || attempts !== 2'd0) begin
            miscompares++;
            $display("FAIL grant4: auth=%b idx=%0d att=%0d, required 1/3/0", auth_ok, acc_index_out, attempts);
        end
        session_end = 1'b1;
        step();
        session_end = 1'b0;
    endtask

    task automatic test_reset_mid_session();
        insert_card(4'd3);
        press(4'd3);
        rst = 1'b1;
        step();
        rst = 1'b0;
        vectors++;
        if (acc_num !== 4'd0 || pin !== 16'd0) begin
            miscompares++;
            $display("FAIL mid_reset: acc=%0d pin=%0d, required 0/0", acc_num, pin);
        end
        insert_card(4'd3);
        press(4'd3); press(4'd4); press(4'd5); press(4'd6);
        step();
        vectors++;
        if (auth_ok !== 1'b1 || locked_reject !== 1'b0 || acc_index_out !== 4'd2) begin
            miscompares++;
            $display("FAIL unlock_by_reset: auth=%b lr=%b idx=%0d, required 1/0/2",
                     auth_ok, locked_reject, acc_index_out);
        end
    endtask

    initial begin
        test_reset();
        test_grant();
        test_lockout();
        test_card_reject();
        test_digit_err();
        test_timeout();
        test_cancel_restart();
        test_reset_mid_session();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
